// File: rtl/issue_sched_if.sv
// -----------------------------------------------------------------------------
// issue_sched_if
// Handshake bundle between the four execution queues and the issue scheduler.
//   issue*_ready    : queue head valid and operands ready (queue -> scheduler)
//   issue*_done     : grant strobe, queue pops its head (scheduler -> queue)
//   cdb_owner       : unit driving the CDB this cycle (00 int, 01 ls, 10 mult, 11 div)
//   cdb_owner_valid : CDB is driven this cycle
//   div_busy        : non-pipelined divider is occupied
// Modports: master = queue side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface issue_sched_if;
    logic       issueint_ready;
    logic       issuels_ready;
    logic       issuemult_ready;
    logic       issuediv_ready;
    logic       issueint_done;
    logic       issuels_done;
    logic       issuemult_done;
    logic       issuediv_done;
    logic [1:0] cdb_owner;
    logic       cdb_owner_valid;
    logic       div_busy;

    modport master (
        output issueint_ready, issuels_ready, issuemult_ready, issuediv_ready,
        input  issueint_done, issuels_done, issuemult_done, issuediv_done,
        input  cdb_owner, cdb_owner_valid, div_busy
    );

    modport slave (
        input  issueint_ready, issuels_ready, issuemult_ready, issuediv_ready,
        output issueint_done, issuels_done, issuemult_done, issuediv_done,
        output cdb_owner, cdb_owner_valid, div_busy
    );
endinterface

// File: rtl/issue_sched.sv
// -----------------------------------------------------------------------------
// issue_sched
// Single-issue scheduler for the int, load/store, multiply and divide queues.
// At most one queue is granted per cycle, and only when the fixed-latency
// result of that unit will find the common data bus free on completion.
// Future CDB ownership is held in a reservation shift register; the
// non-pipelined divider is blocked while its occupancy counter runs.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : issue_sched_if.slave (readies in; dones, CDB owner, div_busy out)
// -----------------------------------------------------------------------------
module issue_sched #(
    parameter int INT_LAT  = 1,
    parameter int LS_LAT   = 1,
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 7   // must be >= every other latency, all >= 1
) (
    input  logic         clk,
    input  logic         reset,
    issue_sched_if.slave bus
);

    localparam int CNT_W = $clog2(DIV_LAT + 1);

    localparam logic [1:0]       OWN_INT  = 2'b00;
    localparam logic [1:0]       OWN_LS   = 2'b01;
    localparam logic [1:0]       OWN_MULT = 2'b10;
    localparam logic [1:0]       OWN_DIV  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LAT - 1);

    typedef struct packed {
        logic       valid;
        logic [1:0] owner;
    } res_t;

    localparam res_t RES_EMPTY = 3'b000;

    // r_res[k] is the CDB owner k cycles from now
    res_t             r_res [0:DIV_LAT];
    res_t             w_res_next [0:DIV_LAT];
    logic [CNT_W-1:0] r_div_cnt;
    logic             r_rr;          // 0 favours int, 1 favours ls

    logic w_elig_int, w_elig_ls, w_elig_mult, w_elig_div;
    logic w_gnt_int, w_gnt_ls, w_gnt_mult, w_gnt_div;

    // A unit of latency L lands in slot L-1 after this cycle's shift, which
    // is the slot currently seen at index L. Grants are suppressed in reset.
    assign w_elig_int  = ~reset & bus.issueint_ready  & ~r_res[INT_LAT].valid;
    assign w_elig_ls   = ~reset & bus.issuels_ready   & ~r_res[LS_LAT].valid;
    assign w_elig_mult = ~reset & bus.issuemult_ready & ~r_res[MULT_LAT].valid;
    assign w_elig_div  = ~reset & bus.issuediv_ready  & ~r_res[DIV_LAT].valid
                       & (r_div_cnt == CNT_ZERO);

    // Fixed priority div > mult > {int, ls}, round robin between int and ls
    always_comb begin
        w_gnt_int  = 1'b0;
        w_gnt_ls   = 1'b0;
        w_gnt_mult = 1'b0;
        w_gnt_div  = 1'b0;
        if (w_elig_div) begin
            w_gnt_div = 1'b1;
        end else if (w_elig_mult) begin
            w_gnt_mult = 1'b1;
        end else if (w_elig_int && (!r_rr || !w_elig_ls)) begin
            w_gnt_int = 1'b1;
        end else if (w_elig_ls) begin
            w_gnt_ls = 1'b1;
        end else begin
            w_gnt_int = 1'b0;
        end
    end

    // Shift reservations one slot closer and book the granted unit's slot
    always_comb begin
        for (int k = 0; k < DIV_LAT; k++) begin
            w_res_next[k] = r_res[k+1];
        end
        w_res_next[DIV_LAT] = RES_EMPTY;
        if (w_gnt_div) begin
            w_res_next[DIV_LAT-1] = {1'b1, OWN_DIV};
        end else if (w_gnt_mult) begin
            w_res_next[MULT_LAT-1] = {1'b1, OWN_MULT};
        end else if (w_gnt_int) begin
            w_res_next[INT_LAT-1] = {1'b1, OWN_INT};
        end else if (w_gnt_ls) begin
            w_res_next[LS_LAT-1] = {1'b1, OWN_LS};
        end else begin
            w_res_next[DIV_LAT] = RES_EMPTY;
        end
    end

    // Reservation register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= DIV_LAT; k++) begin
                r_res[k] <= RES_EMPTY;
            end
        end else begin
            for (int k = 0; k <= DIV_LAT; k++) begin
                r_res[k] <= w_res_next[k];
            end
        end
    end

    // Divider occupancy counter: loaded on grant, counts down to idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= CNT_ZERO;
        end else if (w_gnt_div) begin
            r_div_cnt <= CNT_LOAD;
        end else if (r_div_cnt != CNT_ZERO) begin
            r_div_cnt <= r_div_cnt - CNT_ONE;
        end else begin
            r_div_cnt <= r_div_cnt;
        end
    end

    // Round-robin pointer: flips toward the unit that did not just win
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr <= 1'b0;
        end else if (w_gnt_int) begin
            r_rr <= 1'b1;
        end else if (w_gnt_ls) begin
            r_rr <= 1'b0;
        end else begin
            r_rr <= r_rr;
        end
    end

    assign bus.issueint_done   = w_gnt_int;
    assign bus.issuels_done    = w_gnt_ls;
    assign bus.issuemult_done  = w_gnt_mult;
    assign bus.issuediv_done   = w_gnt_div;
    assign bus.cdb_owner       = r_res[0].owner;
    assign bus.cdb_owner_valid = r_res[0].valid;
    assign bus.div_busy        = (r_div_cnt != CNT_ZERO);

endmodule

// File: tb/tb_issue_sched.sv
// -----------------------------------------------------------------------------
// tb_issue_sched
// Directed, table-driven bench for issue_sched. Ready/done vectors are packed
// {div, mult, ls, int}. Each row is one cycle: inputs driven just after the
// rising edge, outputs compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_issue_sched;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    issue_sched_if bus_if ();

    issue_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    typedef struct {
        logic       rst_before;
        logic [3:0] rdy;
        logic [3:0] done;
        logic       vld;
        logic [1:0] own;
        logic       busy;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic r, input logic [3:0] rdy, input logic [3:0] done,
                       input logic vld, input logic [1:0] own, input logic busy);
        vec_t v;
        v.rst_before = r;
        v.rdy  = rdy;
        v.done = done;
        v.vld  = vld;
        v.own  = own;
        v.busy = busy;
        vecs.push_back(v);
    endtask

    task automatic set_ready(input logic [3:0] rdy);
        bus_if.issuediv_ready  = rdy[3];
        bus_if.issuemult_ready = rdy[2];
        bus_if.issuels_ready   = rdy[1];
        bus_if.issueint_ready  = rdy[0];
    endtask

    task automatic check(input string nm, input logic [3:0] e_done, input logic e_vld,
                         input logic [1:0] e_own, input logic e_busy);
        logic [3:0] a_done;
        a_done = {bus_if.issuediv_done, bus_if.issuemult_done,
                  bus_if.issuels_done, bus_if.issueint_done};
        total++;
        if (a_done !== e_done) begin
            bad++;
            $display("FAIL %s done got=%b want=%b", nm, a_done, e_done);
        end
        total++;
        if (bus_if.cdb_owner_valid !== e_vld) begin
            bad++;
            $display("FAIL %s cdb_valid got=%b want=%b", nm, bus_if.cdb_owner_valid, e_vld);
        end
        total++;
        if (bus_if.div_busy !== e_busy) begin
            bad++;
            $display("FAIL %s div_busy got=%b want=%b", nm, bus_if.div_busy, e_busy);
        end
        if (e_vld) begin
            total++;
            if (bus_if.cdb_owner !== e_own) begin
                bad++;
                $display("FAIL %s cdb_owner got=%b want=%b", nm, bus_if.cdb_owner, e_own);
            end
        end
    endtask

    // Pulse reset across one rising edge; returns 1 ns after that edge
    task automatic do_reset();
        set_ready(4'b0000);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Advance to 1 ns after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        set_ready(4'b0000);

        // Idle after reset release, 10 cycles
        for (int i = 0; i < 10; i++) add(1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0);

        // int and ls ready continuously: alternate, results one cycle later
        add(1'b1, 4'b0011, 4'b0001, 1'b0, 2'b00, 1'b0);
        add(1'b0, 4'b0011, 4'b0010, 1'b1, 2'b00, 1'b0);
        add(1'b0, 4'b0011, 4'b0001, 1'b1, 2'b01, 1'b0);
        add(1'b0, 4'b0011, 4'b0010, 1'b1, 2'b00, 1'b0);
        add(1'b0, 4'b0000, 4'b0000, 1'b1, 2'b01, 1'b0);
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0);

        // mult at c0 owns CDB at c4, so int ready at c3 stalls one cycle
        add(1'b1, 4'b0100, 4'b0100, 1'b0, 2'b00, 1'b0);
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0);
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0);
        add(1'b0, 4'b0001, 4'b0000, 1'b0, 2'b00, 1'b0);
        add(1'b0, 4'b0001, 4'b0001, 1'b1, 2'b10, 1'b0);
        add(1'b0, 4'b0000, 4'b0000, 1'b1, 2'b00, 1'b0);
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0);

        // div ready continuously: grants at c0, c7, c14 only
        for (int c = 0; c < 16; c++) begin
            logic g;
            logic b;
            g = (c == 0) || (c == 7) || (c == 14);
            b = (c != 0) && !g;
            add(c == 0, (c < 15) ? 4'b1000 : 4'b0000, g ? 4'b1000 : 4'b0000,
                (c == 7) || (c == 14), 2'b11, b);
        end

        // All four ready at c0; each queue drops ready once it is served
        add(1'b1, 4'b1111, 4'b1000, 1'b0, 2'b00, 1'b0);
        add(1'b0, 4'b0111, 4'b0100, 1'b0, 2'b00, 1'b1);
        add(1'b0, 4'b0011, 4'b0001, 1'b0, 2'b00, 1'b1);
        add(1'b0, 4'b0010, 4'b0010, 1'b1, 2'b00, 1'b1);
        add(1'b0, 4'b0000, 4'b0000, 1'b1, 2'b01, 1'b1);
        add(1'b0, 4'b0000, 4'b0000, 1'b1, 2'b10, 1'b1);
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b1);
        add(1'b0, 4'b0000, 4'b0000, 1'b1, 2'b11, 1'b0);
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0);

        // div at c0 holds CDB slot for c7, so mult ready at c3 waits to c4
        add(1'b1, 4'b1000, 4'b1000, 1'b0, 2'b00, 1'b0);
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b1);
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b1);
        add(1'b0, 4'b0100, 4'b0000, 1'b0, 2'b00, 1'b1);
        add(1'b0, 4'b0100, 4'b0100, 1'b0, 2'b00, 1'b1);
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b1);
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b1);
        add(1'b0, 4'b0000, 4'b0000, 1'b1, 2'b11, 1'b0);
        add(1'b0, 4'b0000, 4'b0000, 1'b1, 2'b10, 1'b0);
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0);

        // Round-robin pointer holds across idle cycles
        add(1'b1, 4'b0001, 4'b0001, 1'b0, 2'b00, 1'b0);
        add(1'b0, 4'b0000, 4'b0000, 1'b1, 2'b00, 1'b0);
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0);
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0);
        add(1'b0, 4'b0011, 4'b0010, 1'b0, 2'b00, 1'b0);
        add(1'b0, 4'b0011, 4'b0001, 1'b1, 2'b01, 1'b0);
        add(1'b0, 4'b0000, 4'b0000, 1'b1, 2'b00, 1'b0);

        // Outputs held low while reset is high, even with every queue ready
        next_cycle();
        set_ready(4'b1111);
        @(negedge clk);
        check("in_reset", 4'b0000, 1'b0, 2'b00, 1'b0);
        next_cycle();
        reset = 1'b0;
        set_ready(4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) do_reset();
            set_ready(vecs[i].rdy);
            @(negedge clk);
            check($sformatf("row%0d", i), vecs[i].done, vecs[i].vld, vecs[i].own, vecs[i].busy);
            next_cycle();
        end

        // Reset mid-operation: div at c0, mult at c1, reset during c3
        do_reset();
        set_ready(4'b1000);
        @(negedge clk);
        check("mid_c0", 4'b1000, 1'b0, 2'b00, 1'b0);
        next_cycle();
        set_ready(4'b0100);
        @(negedge clk);
        check("mid_c1", 4'b0100, 1'b0, 2'b00, 1'b1);
        next_cycle();
        set_ready(4'b0000);
        @(negedge clk);
        check("mid_c2", 4'b0000, 1'b0, 2'b00, 1'b1);
        next_cycle();
        reset = 1'b1;
        set_ready(4'b1111);
        @(negedge clk);
        check("mid_rst", 4'b0000, 1'b0, 2'b00, 1'b0);
        next_cycle();
        reset = 1'b0;
        set_ready(4'b1000);
        @(negedge clk);
        check("mid_rel", 4'b1000, 1'b0, 2'b00, 1'b0);
        next_cycle();
        set_ready(4'b0000);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check($sformatf("mid_post%0d", c), 4'b0000, 1'b0, 2'b00, 1'b1);
            next_cycle();
        end
        @(negedge clk);
        check("mid_post7", 4'b0000, 1'b1, 2'b11, 1'b0);
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/issue_sched.md
Name: issue_sched

Overview:
- Single-issue scheduler between the four execution queues: integer, load/store, multiply and divide.
- Each cycle it grants at most one queue whose head instruction is ready.
- A grant is given only if that unit's fixed-latency result will find the common data bus (CDB) free in the cycle it completes.
- Tracks future CDB ownership in a reservation shift register and blocks the non-pipelined divider while it is busy; each queue sees the grant as its `*_done` strobe.

Parameters:
- INT_LAT, 1, cycles from integer grant to its CDB broadcast
- LS_LAT, 1, cycles from load/store grant to its CDB broadcast
- MULT_LAT, 4, cycles from multiply grant to CDB broadcast (multiplier fully pipelined)
- DIV_LAT, 7, cycles from divide grant to CDB broadcast (divider non-pipelined); must be >= every other latency; every latency >= 1

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- issueint_ready  input  1  integer queue head valid and operands ready
- issuels_ready  input  1  load/store queue head valid and ready
- issuemult_ready  input  1  multiply queue head valid and ready
- issuediv_ready  input  1  divide queue head valid and ready
- issueint_done  output  1  grant to integer queue this cycle
- issuels_done  output  1  grant to load/store queue this cycle
- issuemult_done  output  1  grant to multiply queue this cycle
- issuediv_done  output  1  grant to divide queue this cycle
- cdb_owner  output  2  unit driving CDB this cycle: 00 int, 01 ls, 10 mult, 11 div
- cdb_owner_valid  output  1  CDB is driven this cycle
- div_busy  output  1  divider occupied

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-high.
- While reset is high:
  - all reservation slots are empty;
  - div_cnt is 0;
  - rr_r is 0 (favour int);
  - all *_done outputs, cdb_owner_valid and div_busy are forced to 0;
  - cdb_owner is 00.
- Reservation register res_r[0..DIV_LAT]: each entry is {valid, owner[1:0]}. res_r[k] is the CDB owner k cycles from now.
  - res_r[0] drives cdb_owner and cdb_owner_valid combinationally from the flops.
  - Next state: res_next[k] = res_r[k+1] for k < DIV_LAT; res_next[DIV_LAT] = empty.
  - A grant to a unit with latency L additionally writes res_next[L-1] = {1, owner}.
- Eligibility, combinational in the current cycle:
  - elig_X = issueX_ready & ~res_r[L_X].valid.
  - Divide additionally requires div_cnt == 0.
- Priority, with exactly one grant or none per cycle:
  - div > mult > {int, ls}.
  - Between int and ls, round robin: rr_r = 0 favours int, rr_r = 1 favours ls.
  - If the favoured unit is not eligible, the other one wins.
  - After an int grant, rr_r <= 1; after an ls grant, rr_r <= 0; otherwise rr_r holds.
- *_done outputs are combinational, same cycle as the ready they answer. A queue shifts its head out on done; done never asserts without the matching ready.
- Divider occupancy:
  - On a div grant, div_cnt <= DIV_LAT-1; otherwise it decrements while non-zero.
  - div_busy = (div_cnt != 0).
  - The next div grant is therefore possible no earlier than DIV_LAT cycles after the previous one.
- Grant latency: a grant at cycle t puts cdb_owner_valid = 1 with that unit's code at cycle t+L.
- Boundary conditions:
  - CDB collision: a slot already reserved is never overwritten, so a ready unit stalls (done = 0) until its target slot is free.
  - Simultaneous div and mult ready with both slots free: div is granted, mult waits one cycle.
  - A grant and a reservation coming due in the same cycle are independent events.
  - Reset asserted mid-operation clears all pending reservations and div_cnt immediately. Results whose grants were issued before the reset produce no cdb_owner_valid.
  - No ready inputs: state only shifts/decrements and rr_r holds.

Test Plan:
- Reset release with all ready = 0 for 10 cycles -> all *_done = 0, cdb_owner_valid = 0, div_busy = 0.
- int and ls ready continuously from c0, others 0 -> grants int c0, ls c1, int c2, ls c3; cdb_owner = 00@c1, 01@c2, 00@c3, 01@c4, all valid.
- mult ready only at c0, int ready only from c3 onward -> mult done c0; int blocked at c3 (slot c4 owned by mult); int done c4; cdb_owner = 10@c4 then 00@c5.
- div ready continuously -> div done at c0, c7, c14 only; div_busy = 1 during c1..c6; cdb_owner = 11 valid at c7 and c14.
- All four ready at c0 -> c0 div, c1 mult, c2 int; cdb_owner = 00@c3, 10@c5, 11@c7.
- div granted c0, mult granted c1, reset pulsed at c3 -> no cdb_owner_valid at c5 or c7; div_busy = 0 after reset; with issuediv_ready = 1 from the first cycle after reset release, issuediv_done = 1 in that same cycle.
